tt_sweep_checker: RTL and testbench

Sequential truth-table sweeper and equivalence checker for 4-input combinational functions. It drives the x/y/w/z inputs of two function instances through all 16 input vectors. It samples both results, builds each function's truth table and counts the vectors where they disagree. It sits directly upstream of the function pair, replacing hand-written stimulus lists, and hands a pass/fail verdict to the bench or to a status display.

---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/tt_vec_gen.sv | 44 ++++
 rtl/tt_sweep_checker.sv | 114 +++++++++++
 tb/tb_tt_sweep_checker.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared widths and FSM state encoding for the truth-table sweep checker.
// Sweep order is selected by TT_SWEEP_GRAY_EN (see tt_vec_gen).
package tt_sweep_pkg;

    localparam int unsigned VEC_W = 4;
    localparam int unsigned N_VEC = 16;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned SET_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/tt_vec_gen.sv
// Step counter and step-to-vector mapping for the sweep.
// TT_SWEEP_GRAY_EN defined: Gray-code order; undefined: binary order.
module tt_vec_gen
    import tt_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [VEC_W-1:0] step,
    output logic [VEC_W-1:0] vec,
    output logic             last
);

    logic [VEC_W-1:0] step_nxt_c;

    function automatic logic [VEC_W-1:0] map_vec(input logic [VEC_W-1:0] s);
`ifdef TT_SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    assign step_nxt_c = step + VEC_W'(1);

    // vec and last are registered with step so they move on the edge that enters APPLY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            vec  <= '0;
            last <= 1'b0;
        end else if (clr) begin
            step <= '0;
            vec  <= map_vec('0);
            last <= 1'b0;
        end else if (inc) begin
            step <= step_nxt_c;
            vec  <= map_vec(step_nxt_c);
            last <= (step_nxt_c == VEC_W'(N_VEC - 1));
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 vectors through a function pair, captures both truth tables
// and counts disagreements. Order selected by TT_SWEEP_GRAY_EN.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             fa,
    input  logic             fb,
    output logic             x,
    output logic             y,
    output logic             w,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [VEC_W-1:0] first_mismatch,
    output logic             any_mismatch,
    output logic [N_VEC-1:0] table_a,
    output logic [N_VEC-1:0] table_b
);

    state_t           state;
    logic [SET_W-1:0] settle_cnt;
    logic [VEC_W-1:0] step;
    logic [VEC_W-1:0] vec;
    logic             last;
    logic             accept_c;
    logic             inc_c;
    logic             mis_c;
    logic [CNT_W-1:0] cnt_nxt_c;

    assign accept_c  = start && ((state == IDLE) || (state == DONE));
    assign inc_c     = (state == SAMPLE) && !last;
    assign mis_c     = fa ^ fb;
    assign cnt_nxt_c = mismatch_count + CNT_W'(mis_c);

    tt_vec_gen u_vec_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (inc_c),
        .clr  (accept_c),
        .step (step),
        .vec  (vec),
        .last (last)
    );

    assign {x, y, w, z} = vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            equal          <= 1'b0;
            mismatch_count <= '0;
            first_mismatch <= '0;
            any_mismatch   <= 1'b0;
            table_a        <= '0;
            table_b        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_c) begin
                        state          <= APPLY;
                        settle_cnt     <= SET_W'(SETTLE - 1);
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        equal          <= 1'b0;
                        mismatch_count <= '0;
                        first_mismatch <= '0;
                        any_mismatch   <= 1'b0;
                        table_a        <= '0;
                        table_b        <= '0;
                    end
                end
                APPLY: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                SAMPLE: begin
                    table_a[vec] <= fa;
                    table_b[vec] <= fb;
                    if (mis_c) begin
                        mismatch_count <= cnt_nxt_c;
                        if (!any_mismatch) begin
                            first_mismatch <= vec;
                            any_mismatch   <= 1'b1;
                        end
                    end
                    if (step == VEC_W'(N_VEC - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        equal <= (cnt_nxt_c == '0);
                    end else begin
                        state      <= APPLY;
                        settle_cnt <= SET_W'(SETTLE - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: two instances (SETTLE = 1 and 3)
// driven by a table-lookup model of the function pair.
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3;
    logic [15:0] fa_tab, fb_tab;

    logic        x1, y1, w1, z1, busy1, done1, eq1, any1;
    logic [4:0]  cnt1;
    logic [3:0]  first1, vec1;
    logic [15:0] ta1, tb1;
    logic        x3, y3, w3, z3, busy3, done3, eq3, any3;
    logic [4:0]  cnt3;
    logic [3:0]  first3, vec3;
    logic [15:0] ta3, tb3;

    int checks = 0;
    int errors = 0;
    int sel = 1;

    always #5 clk = ~clk;

    assign vec1 = {x1, y1, w1, z1};
    assign vec3 = {x3, y3, w3, z3};

    tt_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .fa(fa_tab[vec1]), .fb(fb_tab[vec1]),
        .x(x1), .y(y1), .w(w1), .z(z1),
        .busy(busy1), .done(done1), .equal(eq1),
        .mismatch_count(cnt1), .first_mismatch(first1), .any_mismatch(any1),
        .table_a(ta1), .table_b(tb1)
    );

    tt_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .fa(fa_tab[vec3]), .fb(fb_tab[vec3]),
        .x(x3), .y(y3), .w(w3), .z(z3),
        .busy(busy3), .done(done3), .equal(eq3),
        .mismatch_count(cnt3), .first_mismatch(first3), .any_mismatch(any3),
        .table_a(ta3), .table_b(tb3)
    );

    logic        c_busy, c_done, c_eq, c_any;
    logic [4:0]  c_cnt;
    logic [3:0]  c_first, c_vec;
    logic [15:0] c_ta, c_tb;

    assign c_busy  = (sel == 3) ? busy3  : busy1;
    assign c_done  = (sel == 3) ? done3  : done1;
    assign c_eq    = (sel == 3) ? eq3    : eq1;
    assign c_any   = (sel == 3) ? any3   : any1;
    assign c_cnt   = (sel == 3) ? cnt3   : cnt1;
    assign c_first = (sel == 3) ? first3 : first1;
    assign c_vec   = (sel == 3) ? vec3   : vec1;
    assign c_ta    = (sel == 3) ? ta3    : ta1;
    assign c_tb    = (sel == 3) ? tb3    : tb1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vec"},   32'(c_vec),   32'h0);
        check({tag, "_busy"},  32'(c_busy),  32'h0);
        check({tag, "_done"},  32'(c_done),  32'h0);
        check({tag, "_equal"}, 32'(c_eq),    32'h0);
        check({tag, "_cnt"},   32'(c_cnt),   32'h0);
        check({tag, "_first"}, 32'(c_first), 32'h0);
        check({tag, "_any"},   32'(c_any),   32'h0);
        check({tag, "_ta"},    32'(c_ta),    32'h0);
        check({tag, "_tb"},    32'(c_tb),    32'h0);
    endtask

    task automatic pulse_start(input int s);
        @(negedge clk);
        if (s == 3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic run_sweep(input int s, input string tag, input int exp_cyc,
                             input logic [4:0] exp_cnt, input logic [3:0] exp_first,
                             input logic exp_any, input logic [15:0] exp_ta,
                             input logic [15:0] exp_tb);
        int cyc = 0;
        int overlap = 0;
        int bad = 0;
        int trans = 0;
        logic [3:0] prev;
        sel = s;
        pulse_start(s);
        check({tag, "_acc_busy"}, 32'(c_busy), 32'h1);
        check({tag, "_acc_done"}, 32'(c_done), 32'h0);
        check({tag, "_acc_vec"},  32'(c_vec),  32'h0);
        prev = c_vec;
        while (!c_done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            // a start pulse in the middle of the sweep must be ignored
            if (cyc == 7) begin
                if (s == 3) start3 = 1'b1; else start1 = 1'b1;
            end else if (cyc == 8) begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            if (c_busy && c_done) overlap++;
            if (c_vec != prev) begin
                trans++;
`ifdef TT_SWEEP_GRAY_EN
                if ($countones(c_vec ^ prev) != 1) bad++;
`else
                if (c_vec != 4'(prev + 4'd1)) bad++;
`endif
                prev = c_vec;
            end
        end
        start1 = 1'b0;
        start3 = 1'b0;
        check({tag, "_cycles"},  32'(cyc),       32'(exp_cyc));
        check({tag, "_done"},    32'(c_done),    32'h1);
        check({tag, "_busy"},    32'(c_busy),    32'h0);
        check({tag, "_equal"},   32'(c_eq),      32'(exp_cnt == 5'd0));
        check({tag, "_cnt"},     32'(c_cnt),     32'(exp_cnt));
        check({tag, "_first"},   32'(c_first),   32'(exp_first));
        check({tag, "_any"},     32'(c_any),     32'(exp_any));
        check({tag, "_ta"},      32'(c_ta),      32'(exp_ta));
        check({tag, "_tb"},      32'(c_tb),      32'(exp_tb));
        check({tag, "_overlap"}, 32'(overlap),   32'h0);
        check({tag, "_order"},   32'(bad),       32'h0);
        check({tag, "_trans"},   32'(trans),     32'd15);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        fa_tab = 16'h212D;
        fb_tab = 16'h212D;
        #2;
        sel = 1;
        check_idle("rst1");
        sel = 3;
        check_idle("rst3");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 1;
        check_idle("idle1");

        // identical functions
        run_sweep(1, "same", 32, 5'd0, 4'd0, 1'b0, 16'h212D, 16'h212D);

        // single disagreement at vector 9, restarted from DONE
        fb_tab = 16'h232D;
        run_sweep(1, "one", 32, 5'd1, 4'd9, 1'b1, 16'h212D, 16'h232D);

        // every vector disagrees
        fa_tab = 16'h0000;
        fb_tab = 16'hFFFF;
        run_sweep(1, "all", 32, 5'd16, 4'd0, 1'b1, 16'h0000, 16'hFFFF);

        // longer settle time
        fa_tab = 16'h212D;
        fb_tab = 16'h232D;
        run_sweep(3, "settle3", 64, 5'd1, 4'd9, 1'b1, 16'h212D, 16'h232D);

        // asynchronous reset mid-sweep, then a clean rerun
        sel = 1;
        pulse_start(1);
        repeat (10) @(posedge clk);
        #1;
        check("mid_ta_nonzero", 32'(ta1 != 16'h0), 32'h1);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1, "rerun", 32, 5'd1, 4'd9, 1'b1, 16'h212D, 16'h232D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
